// File: rtl/rf_wb_scheduler.sv
// Writeback port scheduler for the register file.
// Arbitrates ex/mem writebacks and keeps the busy scoreboard.
module rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rs1,
  input  logic [ADDR_W-1:0]      issue_rs2,
  input  logic [ADDR_W-1:0]      issue_rd,
  output logic                   issue_stall,
  input  logic                   ex_valid,
  input  logic [ADDR_W-1:0]      ex_rd,
  input  logic [DATA_W-1:0]      ex_wdata,
  output logic                   ex_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_ready,
  output logic                   rf_en,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int NREG = 2**ADDR_W;
  localparam logic GNT_EX  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_en_q, rf_en_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              last_grant_q, last_grant_d;
  logic              hz_rs1, hz_rs2, hz_rd;
  logic              issue_acc;

  // x0 never holds a pending write, so it never causes a hazard
  always_comb begin
    hz_rs1      = (issue_rs1 != '0) && busy_q[issue_rs1];
    hz_rs2      = (issue_rs2 != '0) && busy_q[issue_rs2];
    hz_rd       = (issue_rd  != '0) && busy_q[issue_rd];
    issue_stall = rst | (issue_valid & (hz_rs1 | hz_rs2 | hz_rd));
    issue_acc   = issue_valid & ~issue_stall;
  end

  always_comb begin
    ex_ready  = ~rst & ex_valid
              & (~mem_valid | (last_grant_q == GNT_MEM));
    mem_ready = ~rst & mem_valid
              & (~ex_valid | (last_grant_q == GNT_EX));
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_en_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    unique case (1'b1)
      ex_ready: begin
        last_grant_d = GNT_EX;
        rf_en_d      = (ex_rd != '0);
        rf_rd_d      = ex_rd;
        rf_wdata_d   = ex_wdata;
      end
      mem_ready: begin
        last_grant_d = GNT_MEM;
        rf_en_d      = (mem_rd != '0);
        rf_rd_d      = mem_rd;
        rf_wdata_d   = mem_wdata;
      end
      default: ;
    endcase
  end

  // a new writer accepted on the clearing edge keeps the bit set
  always_comb begin
    busy_d = busy_q;
    if (rf_en_q)
      busy_d[rf_rd_q] = 1'b0;
    if (issue_acc && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      rf_en_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= GNT_MEM;
    end else begin
      busy_q       <= busy_d;
      rf_en_q      <= rf_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy     = busy_q;
  assign rf_en    = rf_en_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: scenario tasks plus a
// write-port scoreboard fed with the writes each scenario expects.
module tb_rf_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wdata;
  logic        ex_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  logic lg_mem;

  rf_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_wdata(ex_wdata), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write-port scoreboard
  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected rd=%0d data=%h want no write",
                 rf_rd, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd, rf_wdata} !== e) begin
          errors++;
          $display("FAIL wb_order rd=%0d data=%h want rd=%0d data=%h",
                   rf_rd, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (ex_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready ex=%b mem=%b want 0 0",
               ex_ready, mem_ready);
    end
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got=%b want 1", issue_stall);
    end
    checks++;
    if (rf_en !== 1'b0 || busy !== 32'h0) begin
      errors++;
      $display("FAIL reset_state rf_en=%b busy=%h want 0 0",
               rf_en, busy);
    end
    ex_valid = 0; mem_valid = 0;
    @(negedge clk);
    rst = 0;
    issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 5;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL issue_nostall got=%b want 0", issue_stall);
    end
    @(negedge clk);
    issue_valid = 0;
    checks++;
    if (busy !== 32'h20) begin
      errors++;
      $display("FAIL busy_set5 got=%h want 00000020", busy);
    end
    lg_mem = 1;
  endtask

  task automatic test_contention();
    logic g_ex;
    @(negedge clk);
    ex_valid = 1; ex_rd = 3; ex_wdata = 32'h11;
    mem_valid = 1; mem_rd = 4; mem_wdata = 32'h22;
    #1;
    checks++;
    if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL cont_first ex=%b mem=%b want 1 0",
               ex_ready, mem_ready);
    end
    exp_q.push_back({5'd3, 32'h11});
    lg_mem = 0;
    @(negedge clk);
    ex_valid = 0;
    #1;
    checks++;
    if (ex_ready !== 1'b0 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL cont_second ex=%b mem=%b want 0 1",
               ex_ready, mem_ready);
    end
    exp_q.push_back({5'd4, 32'h22});
    lg_mem = 1;
    @(negedge clk);
    ex_valid = 1; ex_rd = 5'($urandom_range(15, 10));
    ex_wdata = $urandom();
    mem_valid = 1; mem_rd = 5'($urandom_range(15, 10));
    mem_wdata = $urandom();
    for (int i = 0; i < 6; i++) begin
      #1;
      g_ex = lg_mem;
      checks++;
      if (ex_ready !== g_ex || mem_ready !== !g_ex) begin
        errors++;
        $display("FAIL cont_alt%0d ex=%b mem=%b want %b %b",
                 i, ex_ready, mem_ready, g_ex, !g_ex);
      end
      if (g_ex) exp_q.push_back({ex_rd, ex_wdata});
      else      exp_q.push_back({mem_rd, mem_wdata});
      lg_mem = !g_ex;
      @(negedge clk);
      if (g_ex) begin
        ex_rd = 5'($urandom_range(15, 10)); ex_wdata = $urandom();
      end else begin
        mem_rd = 5'($urandom_range(15, 10)); mem_wdata = $urandom();
      end
    end
    ex_valid = 0; mem_valid = 0;
  endtask

  task automatic test_raw();
    @(negedge clk);
    issue_valid = 1; issue_rs1 = 5; issue_rs2 = 0; issue_rd = 6;
    ex_valid = 1; ex_rd = 5; ex_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall got=%b want 1", issue_stall);
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_ex_ready got=%b want 1", ex_ready);
    end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    lg_mem = 0;
    @(negedge clk);
    ex_valid = 0;
    #1;
    checks++;
    if (rf_en !== 1'b1 || issue_stall !== 1'b1 || busy[5] !== 1'b1) begin
      errors++;
      $display("FAIL raw_wb rf_en=%b stall=%b busy5=%b want 1 1 1",
               rf_en, issue_stall, busy[5]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy[5] !== 1'b0 || issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_clear busy5=%b stall=%b want 0 0",
               busy[5], issue_stall);
    end
    issue_valid = 0;
  endtask

  task automatic test_x0();
    logic [31:0] b0;
    @(negedge clk);
    b0 = busy;
    issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    ex_valid = 1; ex_rd = 0; ex_wdata = 32'hCAFE0000;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_stall got=%b want 0", issue_stall);
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got=%b want 1", ex_ready);
    end
    lg_mem = 0;
    @(negedge clk);
    issue_valid = 0; ex_valid = 0;
    checks++;
    if (rf_en !== 1'b0 || busy !== b0) begin
      errors++;
      $display("FAIL x0_nowrite rf_en=%b busy=%h want 0 %h",
               rf_en, busy, b0);
    end
  endtask

  task automatic test_setclear();
    @(negedge clk);
    ex_valid = 1; ex_rd = 7; ex_wdata = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    lg_mem = 0;
    @(negedge clk);
    ex_valid = 0;
    issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 7;
    #1;
    checks++;
    if (rf_en !== 1'b1 || rf_rd !== 5'd7 || issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL sc_setup rf_en=%b rd=%0d stall=%b want 1 7 0",
               rf_en, rf_rd, issue_stall);
    end
    @(negedge clk);
    issue_valid = 0;
    checks++;
    if (busy[7] !== 1'b1) begin
      errors++;
      $display("FAIL sc_setwins busy7=%b want 1", busy[7]);
    end
  endtask

  task automatic test_waw_reset();
    @(negedge clk);
    issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 9;
    @(negedge clk);
    #1;
    checks++;
    if (busy[9] !== 1'b1 || issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall busy9=%b stall=%b want 1 1",
               busy[9], issue_stall);
    end
    @(negedge clk);
    rst = 1;
    mem_valid = 1; mem_rd = 9; mem_wdata = 32'h99;
    #1;
    checks++;
    if (mem_ready !== 1'b0 || issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid mem_ready=%b stall=%b want 0 1",
               mem_ready, issue_stall);
    end
    @(negedge clk);
    rst = 0; mem_valid = 0; issue_valid = 0;
    checks++;
    if (busy !== 32'h0 || rf_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state busy=%h rf_en=%b want 0 0",
               busy, rf_en);
    end
    lg_mem = 1;
  endtask

  initial begin
    rst = 1;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    ex_valid = 1; ex_rd = 1; ex_wdata = 32'h1;
    mem_valid = 1; mem_rd = 2; mem_wdata = 32'h2;
    lg_mem = 1;
    test_reset();
    test_contention();
    test_raw();
    test_x0();
    test_setclear();
    test_waw_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_missing left=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Controller that sequences the register file's single synchronous write port and tracks pending destination registers.
- Arbitrates two writeback requesters onto the one write port: execute (ex) and memory/load (mem).
- Keeps a 32-entry busy scoreboard and raises a combinational issue stall on RAW/WAW hazards.
- Sits between the issue/writeback stages and reg_file. It drives reg_file's rf_en, rd and wdata from registered outputs.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  issue stage presents an instruction
issue_rs1  in  ADDR_W  source register 1
issue_rs2  in  ADDR_W  source register 2
issue_rd  in  ADDR_W  destination register (0 = no writeback)
issue_stall  out  1  hazard; issue must hold
ex_valid  in  1  execute writeback request
ex_rd  in  ADDR_W  execute destination
ex_wdata  in  DATA_W  execute result
ex_ready  out  1  execute request accepted this cycle
mem_valid  in  1  memory writeback request
mem_rd  in  ADDR_W  memory destination
mem_wdata  in  DATA_W  load result
mem_ready  out  1  memory request accepted this cycle
rf_en  out  1  register file write enable (registered)
rf_rd  out  ADDR_W  register file write index (registered)
rf_wdata  out  DATA_W  register file write data (registered)
busy  out  2**ADDR_W  scoreboard, bit i = write to xi pending

Behaviour:
Reset (sync, rst=1 at posedge):
- busy=0, rf_en=0, rf_rd=0, rf_wdata=0.
- last_grant=mem, so ex wins the first contention.
- Any in-flight grant is discarded. Reset overrides every other update in the same cycle.

issue_stall (combinational):
- issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), with any index equal to 0 ignored.
- Asserted while rst=1.

Issue accept:
- Accept = issue_valid & !issue_stall.
- If issue_rd != 0, busy[issue_rd] is set at the next posedge.

Arbitration (combinational ready):
- Only ex valid -> ex_ready=1. Only mem valid -> mem_ready=1.
- Both valid -> round-robin: grant the requester not in last_grant. last_grant updates at the edge of each grant.
- At most one ready per cycle. ready=0 while rst=1.
- Requesters hold valid/rd/wdata stable until ready. valid must not depend on ready.

Write port:
- A grant at cycle N loads rf_en=(granted rd != 0), rf_rd, and rf_wdata at posedge N+1.
- rf_en=0 in any cycle with no grant. Latency: request to rf_en is 1 cycle. reg_file captures at posedge N+2.
- Writes to x0 are accepted (ready=1) but never produce rf_en.

Scoreboard clear:
- While rf_en=1, busy[rf_rd] clears at the next posedge, i.e. the same edge reg_file writes.
- Stall therefore drops only once the data is readable from reg_file. No forwarding.

Boundary cases:
- Set and clear of the same index at the same edge: set wins (new pending writer).
- Writeback to a non-busy rd: still written, busy unaffected.
- A stalled issue with issue_valid=0 produces no stall.

Test Plan:
- Reset: rst=1 with both requesters valid -> ex_ready=mem_ready=0, rf_en=0 and busy=0 after the edge. Release rst, issue_rd=5 -> busy[5]=1 the next cycle.
- RAW stall: issue rd=5, then issue rs1=5 -> issue_stall=1. ex writeback rd=5 data=0xDEADBEEF -> rf_en=1, rf_rd=5 one cycle later. busy[5] clears the following edge and issue_stall drops that cycle.
- Contention: ex(rd=3, 0x11) and mem(rd=4, 0x22) held valid together -> ex granted first, mem next cycle. rf writes rd 3 then rd 4 on consecutive cycles. Continuous contention alternates grants.
- x0 handling: issue rd=0 -> busy unchanged. ex writeback rd=0 -> ex_ready=1, rf_en stays 0. rs1=0 with busy[0] never set -> no stall.
- Set/clear same edge: rf_en=1 rf_rd=7 in the same cycle an issue with rd=7 is accepted -> busy[7]=1 after the edge.
- WAW plus reset mid-operation: busy[9]=1, then issue rd=9 -> stall. Assert rst while an mem grant is pending -> busy=0, rf_en=0 next cycle, no write to x9.
